// File: rtl/serial_cla_subtractor_pkg.sv
// Shared definitions for the nibble-serial lookahead subtractor.
package sub_pkg;

    // Datapath slice width; the operand is consumed this many bits per cycle.
    localparam int NIB_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_cla_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
interface serial_cla_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_cla_subtractor_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with flattened carries.
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = x ^ y;
    assign g = x & y;

    // Every carry is a two-level sum of products of g, p and c_in.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;
endmodule

// File: rtl/serial_cla_subtractor.sv
// Nibble-serial two's-complement subtractor: diff = a - b over WIDTH/4 cycles.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | waiting for an operand pair (in_ready high)
// S_CALC | one nibble per clock through the lookahead slice
// S_DONE | result presented until out_ready
module serial_cla_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_cla_subtractor_if.slave  bus
);
    localparam int N  = WIDTH / NIB_W;
    localparam int KW = idx_width(N);
    localparam int MSB = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t state_q, state_d;

    logic [N-1:0][NIB_W-1:0] a_q;
    logic [N-1:0][NIB_W-1:0] b_q;
    logic [N-1:0][NIB_W-1:0] diff_q;
    logic [KW-1:0]           k_q;
    logic                    carry_q;
    logic                    borrow_q;
    logic                    overflow_q;

    logic             accept;
    logic             last_nib;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_inv;
    logic [NIB_W-1:0] s_nib;
    logic             c_out;

    assign a_nib = a_q[k_q];
    assign b_inv = ~b_q[k_q];

    cla4_slice u_slice (
        .x     (a_nib),
        .y     (b_inv),
        .c_in  (carry_q),
        .s     (s_nib),
        .c_out (c_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_nib = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (k_q == K_LAST) begin
                    last_nib = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, nibble-serial accumulation and flag capture on the last nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            k_q        <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            k_q     <= '0;
            carry_q <= 1'b1;
        end else if (state_q == S_CALC) begin
            diff_q[k_q] <= s_nib;
            carry_q     <= c_out;
            if (last_nib) begin
                // Flags are registered here so they hold until the next result.
                borrow_q   <= ~c_out;
                overflow_q <= (a_q[N-1][NIB_W-1] != b_q[N-1][NIB_W-1])
                           && (s_nib[NIB_W-1] != a_q[N-1][NIB_W-1]);
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    // Handshake outputs come from state only; rst masks in_ready while asserted.
    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = overflow_q;

    logic unused_msb;
    assign unused_msb = ^MSB;
endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Directed and randomized check of serial_cla_subtractor at WIDTH 4, 16 and 32.
module tb_serial_cla_subtractor;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_cla_subtractor_if #(.WIDTH(4))  if4  ();
    serial_cla_subtractor_if #(.WIDTH(16)) if16 ();
    serial_cla_subtractor_if #(.WIDTH(32)) if32 ();

    serial_cla_subtractor #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    serial_cla_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    serial_cla_subtractor #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        borrow;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int w, input logic v, input logic [31:0] a, input logic [31:0] b);
        case (w)
            4:       begin if4.in_valid  = v; if4.a  = a[3:0];  if4.b  = b[3:0];  end
            32:      begin if32.in_valid = v; if32.a = a;       if32.b = b;       end
            default: begin if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic v);
        case (w)
            4:       if4.out_ready  = v;
            32:      if32.out_ready = v;
            default: if16.out_ready = v;
        endcase
    endtask

    function automatic logic get_ovld(input int w);
        case (w)
            4:       return if4.out_valid;
            32:      return if32.out_valid;
            default: return if16.out_valid;
        endcase
    endfunction

    function automatic logic get_irdy(input int w);
        case (w)
            4:       return if4.in_ready;
            32:      return if32.in_ready;
            default: return if16.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_diff(input int w);
        case (w)
            4:       return {28'd0, if4.diff};
            32:      return if32.diff;
            default: return {16'd0, if16.diff};
        endcase
    endfunction

    function automatic logic [1:0] get_flags(input int w);
        case (w)
            4:       return {if4.borrow, if4.overflow};
            32:      return {if32.borrow, if32.overflow};
            default: return {if16.borrow, if16.overflow};
        endcase
    endfunction

    // Called at a negedge right after the accept edge; counts edges until out_valid.
    task automatic wait_done(input int w, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (get_ovld(w)) break;
        end
        if (!get_ovld(w)) chk("out_valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic handshake_out(input int w);
        set_ordy(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ordy(w, 1'b0);
    endtask

    // Full operation from IDLE at a negedge; returns result and latency.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic [1:0] fl, output int lat);
        chk("in_ready_idle", 64'(get_irdy(w)), 64'(1));
        set_in(w, 1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        set_in(w, 1'b0, 32'd0, 32'd0);
        wait_done(w, lat);
        d  = get_diff(w);
        fl = get_flags(w);
        handshake_out(w);
        chk("out_valid_after_hs", 64'(get_ovld(w)), 64'(0));
    endtask

    vec_t        vecs[6];
    logic [31:0] d;
    logic [1:0]  fl;
    int          lat;

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0, 1'b1};

        rst = 1'b1;
        for (int w = 4; w <= 32; w = w * 2) begin
            set_in(w, 1'b0, 32'd0, 32'd0);
            set_ordy(w, 1'b0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(if16.in_ready),  64'(0));
        chk("rst_out_valid", 64'(if16.out_valid), 64'(0));
        chk("rst_diff",      64'(if16.diff),      64'(0));
        chk("rst_flags",     64'({if16.borrow, if16.overflow}), 64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(if16.in_ready), 64'(1));
        @(negedge clk);

        // Directed 16-bit table.
        for (int i = 0; i < 6; i++) begin
            do_op(16, {16'd0, vecs[i].a}, {16'd0, vecs[i].b}, d, fl, lat);
            chk($sformatf("v%0d_diff", i),    64'(d[15:0]), 64'(vecs[i].diff));
            chk($sformatf("v%0d_borrow", i),  64'(fl[1]),   64'(vecs[i].borrow));
            chk($sformatf("v%0d_ovf", i),     64'(fl[0]),   64'(vecs[i].ovf));
            chk($sformatf("v%0d_latency", i), 64'(lat),     64'(4));
        end

        // Backpressure with a new operand pair waiting on the input.
        begin
            logic stable_ok;
            set_in(16, 1'b1, 32'h1234, 32'h0234);
            @(posedge clk);
            @(negedge clk);
            set_in(16, 1'b1, 32'h0005, 32'h0003);
            wait_done(16, lat);
            chk("bp_latency", 64'(lat), 64'(4));
            stable_ok = 1'b1;
            for (int c = 0; c < 10; c++) begin
                if (if16.diff !== 16'h1000 || if16.out_valid !== 1'b1 || if16.in_ready !== 1'b0
                    || if16.borrow !== 1'b0 || if16.overflow !== 1'b0)
                    stable_ok = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            chk("bp_hold_stable", 64'(stable_ok), 64'(1));
            handshake_out(16);
            chk("bp_idle_out_valid", 64'(if16.out_valid), 64'(0));
            chk("bp_idle_in_ready",  64'(if16.in_ready),  64'(1));
            @(posedge clk);
            @(negedge clk);
            set_in(16, 1'b0, 32'd0, 32'd0);
            chk("bp_accepted_busy", 64'(if16.in_ready), 64'(0));
            wait_done(16, lat);
            chk("bp_second_diff",    64'(if16.diff),   64'(16'h0002));
            chk("bp_second_borrow",  64'(if16.borrow), 64'(0));
            chk("bp_second_latency", 64'(lat),         64'(4));
            handshake_out(16);
        end

        // Reset in the middle of CALC, with nibble index at 2.
        begin
            logic rose;
            set_in(16, 1'b1, 32'h1234, 32'h0234);
            @(posedge clk);
            @(negedge clk);
            set_in(16, 1'b0, 32'd0, 32'd0);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("abort_in_ready_rst", 64'(if16.in_ready),  64'(0));
            chk("abort_out_valid",    64'(if16.out_valid), 64'(0));
            chk("abort_diff",         64'(if16.diff),      64'(0));
            chk("abort_flags",        64'({if16.borrow, if16.overflow}), 64'(0));
            rst = 1'b0;
            #1;
            chk("abort_in_ready_after", 64'(if16.in_ready), 64'(1));
            rose = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (if16.out_valid) rose = 1'b1;
            end
            chk("abort_no_result", 64'(rose), 64'(0));
            do_op(16, 32'h0005, 32'h0003, d, fl, lat);
            chk("abort_next_diff",   64'(d[15:0]), 64'(16'h0002));
            chk("abort_next_borrow", 64'(fl[1]),   64'(0));
        end

        // Randomized sweeps at WIDTH 4 and 32 against an arithmetic reference.
        for (int w = 4; w <= 32; w = w * 8) begin
            for (int i = 0; i < 20; i++) begin
                logic [31:0] mask, a, b, exp_d;
                longint      sa, sb, r, lim;
                logic        exp_b, exp_o;
                mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
                a     = $urandom() & mask;
                b     = $urandom() & mask;
                if (i == 0) begin a = 32'd0;  b = mask; end
                if (i == 1) begin a = mask >> 1; b = mask; end
                exp_d = (a - b) & mask;
                exp_b = (a < b);
                lim   = longint'(64'd1) << (w - 1);
                sa    = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
                sb    = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
                r     = sa - sb;
                exp_o = (r >= lim) || (r < -lim);
                do_op(w, a, b, d, fl, lat);
                chk($sformatf("w%0d_r%0d_diff", w, i),    64'(d),     64'(exp_d));
                chk($sformatf("w%0d_r%0d_borrow", w, i),  64'(fl[1]), 64'(exp_b));
                chk($sformatf("w%0d_r%0d_ovf", w, i),     64'(fl[0]), 64'(exp_o));
                chk($sformatf("w%0d_r%0d_latency", w, i), 64'(lat),   64'(w / 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
